// File: rtl/lcd_reader.sv
// ---------------------------------------------------------------------------
// lcd_reader
//
// Nios II custom-instruction block that performs HD44780 read cycles (RW=1)
// on the character LCD. It is the read side of the LCD command path: it
// returns busy-flag/address-counter reads, DDRAM/CGRAM data reads, and can
// poll the busy flag until the panel is ready. The LCD pins belong to this
// block only while lcd_rd_active is high; the top level muxes on it.
//
// Operations (dataa[1:0]):
//   00 : single read, RS=0 (BF + AC)
//   01 : single read, RS=1 (data RAM byte)
//   10 : poll RS=0 reads until BF=0
//   11 : reserved, completes next cycle with result=0
//
// Result: [7:0] byte, [8] BF (0 for op 01), [23:16] read count,
//         [31] poll timeout flag, all other bits 0.
//
// Compile-time option:
//   LCD_READ_TIMEOUT_EN - when defined, op 10 gives up after POLL_MAX reads
//                         and sets result[31]. Otherwise it polls forever.
//
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   clk_en            : Nios clock enable; low freezes FSM, counters, pins
//   start             : one-cycle instruction strobe (sampled only in IDLE)
//   dataa, datab      : operands; only dataa[1:0] is used
//   done, result      : completion pulse and read result
//   lcd_data_in       : D7..D0 from the pads
//   lcd_rs/rw/en      : LCD control pins
//   lcd_backlight     : constant 1
//   lcd_rd_active     : pin-ownership request to the top-level mux
//   o_dbg_state       : current FSM state encoding
//
// Handshake: start is a single-cycle strobe qualified by clk_en and accepted
// only in IDLE (no queueing); done is high for exactly one enabled cycle and
// result is valid in that cycle and holds until the next completion.
// ---------------------------------------------------------------------------
module lcd_reader #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned GAP_CYC     = 9,
  parameter int unsigned POLL_MAX    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  input  logic [7:0]  lcd_data_in,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_backlight,
  output logic        lcd_rd_active,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_EN_HIGH = 3'd2,
    S_HOLD    = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] LP_SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] LP_EN_LAST    = 8'(EN_HIGH_CYC - 1);
  localparam logic [7:0] LP_HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] LP_GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [7:0] LP_POLL_MAX   = 8'(POLL_MAX);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_phase;
  logic [1:0]  r_op;
  logic [7:0]  r_data;
  logic [7:0]  r_reads;
  logic [31:0] r_result;

  logic        w_phase_last;
  logic        w_poll_limit;
  logic        w_timeout;
  logic        w_poll_again;
  logic        w_timeout_hit;
  logic        w_bf;
  logic [31:0] w_result_fmt;
  logic        w_unused;

  // Poll limit reached once the read count has hit POLL_MAX.
  assign w_poll_limit = (r_reads >= LP_POLL_MAX);

`ifdef LCD_READ_TIMEOUT_EN
  assign w_timeout = w_poll_limit;
  assign w_unused  = ^{dataa[31:2], datab};
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^{dataa[31:2], datab, w_poll_limit};
`endif

  // After HOLD, a poll keeps going while the captured busy flag is set.
  assign w_poll_again  = (r_op == 2'b10) && r_data[7] && !w_timeout;
  assign w_timeout_hit = (r_op == 2'b10) && r_data[7] && w_timeout;
  assign w_bf          = (r_op != 2'b01) && r_data[7];
  assign w_result_fmt  = {w_timeout_hit, 7'd0, r_reads, 7'd0, w_bf, r_data};

  // Last cycle of the timed states.
  always_comb begin
    w_phase_last = 1'b0;
    case (r_state)
      S_SETUP:   w_phase_last = (r_phase == LP_SETUP_LAST);
      S_EN_HIGH: w_phase_last = (r_phase == LP_EN_LAST);
      S_HOLD:    w_phase_last = (r_phase == LP_HOLD_LAST);
      S_GAP:     w_phase_last = (r_phase == LP_GAP_LAST);
      default:   w_phase_last = 1'b0;
    endcase
  end

  // Next-state logic; nothing advances while clk_en is low.
  always_comb begin
    w_next = r_state;
    if (clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_next = (dataa[1:0] == 2'b11) ? S_DONE : S_SETUP;
          end
        end
        S_SETUP:   if (w_phase_last) w_next = S_EN_HIGH;
        S_EN_HIGH: if (w_phase_last) w_next = S_HOLD;
        S_HOLD: begin
          if (w_phase_last) begin
            w_next = w_poll_again ? S_GAP : S_DONE;
          end
        end
        S_GAP:     if (w_phase_last) w_next = S_SETUP;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Phase counter restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= 8'd0;
    end else if (clk_en) begin
      if (w_next != r_state) begin
        r_phase <= 8'd0;
      end else begin
        r_phase <= r_phase + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= 2'b00;
      r_data   <= 8'd0;
      r_reads  <= 8'd0;
      r_result <= 32'd0;
    end else if (clk_en) begin
      if (r_state == S_IDLE && start) begin
        r_op    <= dataa[1:0];
        r_reads <= 8'd0;
      end
      // Sample on the last EN-high cycle, when the panel data is settled.
      if (r_state == S_EN_HIGH && w_phase_last) begin
        r_data <= lcd_data_in;
        if (r_reads != 8'hFF) begin
          r_reads <= r_reads + 8'd1;
        end
      end
      // Result is loaded on entry to DONE so it is valid with done.
      // Only the reserved op reaches DONE straight from IDLE.
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_result <= (r_state == S_IDLE) ? 32'd0 : w_result_fmt;
      end
    end
  end

  assign done          = (r_state == S_DONE);
  assign result        = r_result;
  assign lcd_rd_active = (r_state == S_SETUP) || (r_state == S_EN_HIGH) ||
                         (r_state == S_HOLD)  || (r_state == S_GAP);
  assign lcd_rw        = lcd_rd_active;
  assign lcd_rs        = lcd_rd_active && (r_op == 2'b01);
  assign lcd_en        = (r_state == S_EN_HIGH);
  assign lcd_backlight = 1'b1;
  assign o_dbg_state   = r_state;

endmodule
